// File: rtl/sequence_detector_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// next_state() builds the KMP-style transition table from the pattern.
package seqdet_pkg;

    localparam int          DEF_SEQ_LEN = 4;
    localparam logic [15:0] DEF_SEQ     = 16'h000A;
    localparam int          MAX_SEQ_LEN = 16;

    function automatic int state_width(input int len);
        return $clog2(len + 1);
    endfunction

    // k = bits matched so far, b = incoming bit; returns the longest pattern
    // prefix that is a suffix of (matched prefix + b). Pattern bit i is seq[len-1-i].
    function automatic int next_state(input int k, input logic b, input logic [15:0] seq,
                                      input int len, input bit overlap);
        logic [16:0] s;
        int          kk;
        int          best;
        bit          ok;
        s    = '0;
        kk   = (k > len || (k == len && !overlap)) ? 0 : k;
        best = 0;
        for (int i = 0; i < MAX_SEQ_LEN; i++)
            if (i < kk) s[i] = seq[len-1-i];
        s[kk] = b;
        for (int j = 1; j <= MAX_SEQ_LEN; j++) begin
            if (j <= kk + 1 && j <= len) begin
                ok = 1'b1;
                for (int m = 0; m < MAX_SEQ_LEN; m++)
                    if (m < j && s[kk+1-j+m] != seq[len-1-m]) ok = 1'b0;
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/sequence_detector_if.sv
// Serial bit in / match flag out of the pattern detector.
interface sequence_detector_if;
    logic x;
    logic y;

    modport master (output x, input  y);
    modport slave  (input  x, output y);
endinterface

// File: rtl/sequence_detector_fsm_core.sv
// Match-length state register and table-driven next-state logic.
module seqdet_fsm_core
    import seqdet_pkg::*;
#(
    parameter int               SEQ_LEN = DEF_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] SEQ   = DEF_SEQ[SEQ_LEN-1:0],
    parameter bit               OVERLAP = 1'b1,
    localparam int              SW      = state_width(SEQ_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x,
    output logic [SW-1:0] state_nxt
);

    logic [SW-1:0] state;
    logic [SW-1:0] tbl0 [SEQ_LEN+1];
    logic [SW-1:0] tbl1 [SEQ_LEN+1];

    // Transition table is fully constant after elaboration.
    for (genvar k = 0; k <= SEQ_LEN; k++) begin : g_tbl
        assign tbl0[k] = SW'(next_state(k, 1'b0, 16'(SEQ), SEQ_LEN, OVERLAP));
        assign tbl1[k] = SW'(next_state(k, 1'b1, 16'(SEQ), SEQ_LEN, OVERLAP));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= '0;
        else        state <= state_nxt;
    end

    // Encodings above SEQ_LEN keep the '0 default and fall back to S0.
    always_comb begin
        state_nxt = '0;
        for (int k = 0; k <= SEQ_LEN; k++)
            if (state == SW'(k)) state_nxt = x ? tbl1[k] : tbl0[k];
    end

endmodule

// File: rtl/sequence_detector.sv
// Serial pattern detector top: parameter checks plus registered Moore match flag.
module sequence_detector
    import seqdet_pkg::*;
#(
    parameter int                 SEQ_LEN = DEF_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] SEQ     = DEF_SEQ[SEQ_LEN-1:0],
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    sequence_detector_if.slave bus
);

    localparam int            SW   = state_width(SEQ_LEN);
    localparam logic [SW-1:0] LAST = SW'(SEQ_LEN);

    if (SEQ_LEN < 2 || SEQ_LEN > MAX_SEQ_LEN) begin : g_bad_len
        $error("sequence_detector: SEQ_LEN must be in 2..16");
    end

    logic [SW-1:0] state_nxt;
    logic          y_q;

    seqdet_fsm_core #(
        .SEQ_LEN (SEQ_LEN),
        .SEQ     (SEQ),
        .OVERLAP (OVERLAP)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .x         (bus.x),
        .state_nxt (state_nxt)
    );

    // Loading from next-state keeps y aligned with state == S_SEQ_LEN
    // while leaving no combinational path from x to y.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) y_q <= 1'b0;
        else        y_q <= (state_nxt == LAST);
    end

    assign bus.y = y_q;

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench: default 1010 pattern, overlapping and non-overlapping instances in parallel.
module tb_sequence_detector;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sequence_detector_if ifo ();
    sequence_detector_if ifn ();

    sequence_detector #(.SEQ_LEN(4), .SEQ(4'b1010), .OVERLAP(1'b1)) dut_ovl (
        .clk   (clk),
        .reset (reset),
        .bus   (ifo)
    );

    sequence_detector #(.SEQ_LEN(4), .SEQ(4'b1010), .OVERLAP(1'b0)) dut_nov (
        .clk   (clk),
        .reset (reset),
        .bus   (ifn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one bit, let it be sampled, then check both instances.
    task automatic step(input logic b, input logic exp_o, input logic exp_n, input string tag);
        ifo.x = b;
        ifn.x = b;
        @(posedge clk);
        #1;
        chk({tag, "_ovl"}, ifo.y, exp_o);
        chk({tag, "_nov"}, ifn.y, exp_n);
    endtask

    logic [15:0] stream;
    logic [15:0] exp_ovl;
    logic [15:0] exp_nov;
    logic [9:0]  near;
    logic [3:0]  pat;

    initial begin
        checks   = 0;
        failures = 0;
        stream   = 16'b1010_1001_0101_0101;
        exp_ovl  = 16'b0001_0100_0010_1010;
        exp_nov  = 16'b0001_0000_0010_0010;
        near     = 10'b1101100100;
        pat      = 4'b1010;

        // Reset held for two edges with x toggling
        reset = 1'b0;
        ifo.x = 1'b1;
        ifn.x = 1'b1;
        #1;
        chk("rst_init_ovl", ifo.y, 1'b0);
        chk("rst_init_nov", ifn.y, 1'b0);
        step(1'b0, 1'b0, 1'b0, "rst_hold0");
        step(1'b1, 1'b0, 1'b0, "rst_hold1");
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, "rel_x0");

        // Single match
        for (int i = 3; i >= 0; i--)
            step(pat[i], i == 0, i == 0, $sformatf("single_e%0d", 4 - i));
        step(1'b0, 1'b0, 1'b0, "single_tail");

        // Overlapping vs non-overlapping on the same stream
        for (int i = 15; i >= 0; i--)
            step(stream[i], exp_ovl[i], exp_nov[i], $sformatf("ovl_e%0d", 16 - i));

        // Both instances reach S1 before the near-miss stream
        step(1'b1, 1'b0, 1'b0, "near_pre");
        for (int i = 9; i >= 0; i--)
            step(near[i], 1'b0, 1'b0, $sformatf("near_e%0d", 10 - i));

        // Async reset mid-pattern discards the partial match
        step(1'b1, 1'b0, 1'b0, "mid_e1");
        step(1'b0, 1'b0, 1'b0, "mid_e2");
        step(1'b1, 1'b0, 1'b0, "mid_e3");
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, "mid_in_rst");
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, "mid_after_rel");
        for (int i = 3; i >= 0; i--)
            step(pat[i], i == 0, i == 0, $sformatf("mid_match_e%0d", 4 - i));

        // Reset assertion clears a high y without waiting for a clock edge
        #1;
        reset = 1'b0;
        #1;
        chk("async_clr_ovl", ifo.y, 1'b0);
        chk("async_clr_nov", ifn.y, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequence_detector.md
Name: sequence_detector

Overview:
- Serial bit-pattern detector. Samples one input bit `x` per rising clock edge and flags each completed occurrence of a fixed pattern.
- Default pattern is 1010, received MSB first. Overlapping matches are detected.
- Moore-style registered output. Intended as a leaf block in serial-protocol front ends.

Parameters:
- SEQ_LEN, 4, pattern length in bits (legal range 2..16).
- SEQ, 4'b1010, pattern; SEQ[SEQ_LEN-1] is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = after a match, matching restarts from an empty prefix.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- x  input  1  serial data bit, sampled on rising edge of clk.
- y  output  1  match flag; high for one cycle per completed pattern.

Behaviour:
- Single clock, `clk`. Reset is asynchronous and active-low on port `reset`.
- Reset value:
  - State = S0 (zero bits matched); y = 0, driven immediately on `reset` going low.
  - Release is synchronous to the next rising edge (no glitch requirement beyond standard async-assert/sync-deassert behaviour).
- States: S0..S_SEQ_LEN, where state k means the last k sampled bits equal the first k pattern bits (longest such prefix).
- Default states: S0 (idle), S1 ("1"), S2 ("10"), S3 ("101"), S4 ("1010", match).
- Output is Moore: y = 1 exactly when state == S_SEQ_LEN. y is registered, with no combinational path from x to y.
- Latency: y rises in the clock cycle that starts at the edge sampling the final pattern bit. It is valid until the next edge.
- Transitions, state k < SEQ_LEN:
  - If x equals pattern bit k, go to S(k+1).
  - Otherwise go to the longest proper prefix length j such that (matched prefix + x) ends with pattern prefix j. This is a KMP failure transition, computed at elaboration from SEQ.
- Transitions from S_SEQ_LEN:
  - OVERLAP=1: same failure rule applied to the full match.
  - OVERLAP=0: treat as S0 for the incoming bit.
- Default transition table (1010, OVERLAP=1):
  - S0: 0→S0, 1→S1
  - S1: 0→S2, 1→S1
  - S2: 0→S0, 1→S3
  - S3: 0→S4, 1→S1
  - S4: 0→S0, 1→S3
- Back-to-back matches: with OVERLAP=1 and stream 1010 10, y pulses high, low, high (every second cycle for period-2 patterns).
- Reset mid-sequence: partial match is discarded; detection restarts from S0 after release.
- x is sampled only while reset is deasserted. Input values during reset are ignored.
- State register width: clog2(SEQ_LEN+1) bits. Unused encodings go to S0.

Decomposition:
- Shared package `seqdet_pkg`:
  - default SEQ/SEQ_LEN constants
  - elaboration-time function `next_state(k, bit)` computing the prefix-function transition
  - state-width helper function
- One sub-module is natural: `seqdet_fsm_core`, holding the state register and next-state logic. The top adds the parameter checks (SEQ_LEN range) and the output register.

Test Plan:
- Reset: hold reset=0 for 2 cycles with x toggling → y=0 throughout, state S0. After release with x=0 → y stays 0.
- Single match: bits 1,0,1,0 on consecutive edges → y=1 only in the cycle after the 4th edge, 0 otherwise.
- Overlap (OVERLAP=1): bits 1,0,1,0,1,0,0,1,0,1,0,1,0,1,0,1 → y=1 after edges 4, 6, 11, 13, 15. These are exactly 5 single-cycle pulses.
- No-overlap (OVERLAP=0) on the same stream → y=1 after edges 4, 11, 15 only.
- Near misses: 1,1,0,1,1,0,0,1,0,0 → y never asserts. Checks the failure transitions S1→S1, S3→S1 and S2→S0.
- Async reset mid-pattern: feed 1,0,1, assert reset=0 between edges, release, then feed 0 → no match. Then 1,0,1,0 → y=1 after that 4th edge.
